// File: rtl/nb_seq_pkg.sv
// Shared definitions for the layer sequencer: opcode and state encodings
// plus small state-classification helpers used by the top level.
package nb_seq_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 4'h0,
        OP_LAYER = 4'h1,
        OP_ROWS  = 4'h2,
        OP_COST  = 4'h3,
        OP_LOAD  = 4'h4,
        OP_FWD   = 4'h5,
        OP_BWD   = 4'h6,
        OP_END   = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_LOAD_ROWS = 3'd3,
        ST_WAIT_FWD  = 3'd4,
        ST_WAIT_BWD  = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERR       = 3'd7
    } state_e;

    // States in which the host owns the code RAM and start is honoured.
    function automatic logic is_host_state(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

    // States reported as busy.
    function automatic logic is_busy_state(input state_e s);
        return !is_host_state(s);
    endfunction

endpackage

// File: rtl/seq_code_ram.sv
// Program store for the layer sequencer: DEPTH x INSTR_W, one write port and
// one synchronous read port (1-cycle latency). A read and a write to the same
// address in one cycle return the old contents. Contents are never reset.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module seq_code_ram #(
    parameter  int INSTR_W = 12,
    parameter  int DEPTH   = 256,
    localparam int PC_W    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PC_W-1:0]    waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [PC_W-1:0]    raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_r [DEPTH];

    // Write port and registered read port (read-before-write on collision).
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: runs a network program out of a code RAM, latches layer
// parameters and issues weight-row loads plus forward/backprop handshakes.
// Optional feature macro: SEQ_BACKPROP_EN enables the BWD opcode (bwd_start /
// bwd_done); without it BWD is illegal, bwd_start is 0 and bwd_done is unused.
// Ports: clk_clk, reset_reset (sync, active high); code_write* host download;
// start; w_load_valid/ready with w_layer_index/w_row_index; fwd_start/done;
// bwd_start/done; act_type, dense_type, cost_type; busy, done, error.
// All outputs are registered.
module layer_sequencer
    import nb_seq_pkg::*;
#(
    parameter  int INSTR_W    = 12,
    parameter  int DEPTH      = 256,
    parameter  int MAX_LAYERS = 8,
    parameter  int ROW_W      = 8,
    localparam int PC_W       = $clog2(DEPTH),
    localparam int LI_W       = $clog2(MAX_LAYERS),
    localparam int ARG_W      = INSTR_W - OPC_W
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               code_write,
    input  logic [PC_W-1:0]    code_write_line,
    input  logic [INSTR_W-1:0] code_write_data,
    input  logic               start,
    output logic               w_load_valid,
    input  logic               w_load_ready,
    output logic [LI_W-1:0]    w_layer_index,
    output logic [ROW_W-1:0]   w_row_index,
    output logic               fwd_start,
    input  logic               fwd_done,
    output logic               bwd_start,
    input  logic               bwd_done,
    output logic [3:0]         act_type,
    output logic [3:0]         dense_type,
    output logic [7:0]         cost_type,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(DEPTH - 1);
    localparam logic [LI_W-1:0] LI_LAST = LI_W'(MAX_LAYERS - 1);

    state_e             state_r, state_s;
    logic [PC_W-1:0]    pc_r, pc_s;
    logic               wrap_r, wrap_s;     // PC ran past the last entry
    logic               seen_r, seen_s;     // a LAYER has been executed
    logic [LI_W-1:0]    layer_r, layer_s;
    logic [ROW_W-1:0]   rows_r, rows_s;
    logic [ROW_W-1:0]   row_idx_r, row_idx_s;
    logic               valid_r, valid_s;
    logic               fwd_start_r, fwd_start_s;
    logic               bwd_start_r, bwd_start_s;
    logic [3:0]         act_r, act_s;
    logic [3:0]         dense_r, dense_s;
    logic [7:0]         cost_r, cost_s;
    logic               busy_r, done_r, error_r;

    logic [INSTR_W-1:0] rd_data_s;
    logic               we_s;
    op_e                op_s;
    logic [ARG_W-1:0]   arg_s;

    assign we_s  = code_write & is_host_state(state_r);
    assign op_s  = op_e'(rd_data_s[INSTR_W-1 -: OPC_W]);
    assign arg_s = rd_data_s[ARG_W-1:0];

    // The read address follows the PC; data lines up with the DECODE cycle.
    seq_code_ram #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_code_ram (
        .clk   (clk_clk),
        .we    (we_s),
        .waddr (code_write_line),
        .wdata (code_write_data),
        .raddr (pc_r),
        .rdata (rd_data_s)
    );

`ifdef SEQ_BACKPROP_EN
`else
    logic unused_bwd_done_s;
    assign unused_bwd_done_s = bwd_done;
`endif

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        wrap_s      = wrap_r;
        seen_s      = seen_r;
        layer_s     = layer_r;
        rows_s      = rows_r;
        row_idx_s   = row_idx_r;
        valid_s     = valid_r;
        fwd_start_s = 1'b0;
        bwd_start_s = 1'b0;
        act_s       = act_r;
        dense_s     = dense_r;
        cost_s      = cost_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    // A (re)run starts from PC 0 with all layer state cleared.
                    state_s   = ST_FETCH;
                    pc_s      = {PC_W{1'b0}};
                    wrap_s    = 1'b0;
                    seen_s    = 1'b0;
                    layer_s   = {LI_W{1'b0}};
                    rows_s    = {ROW_W{1'b0}};
                    row_idx_s = {ROW_W{1'b0}};
                    act_s     = 4'h0;
                    dense_s   = 4'h0;
                    cost_s    = 8'h00;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                if (wrap_r) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_DECODE;
                end
            end
            ST_DECODE: begin
                pc_s    = pc_r + PC_W'(1);
                state_s = ST_FETCH;
                if (pc_r == PC_LAST) begin
                    wrap_s = 1'b1;
                end else begin
                    wrap_s = wrap_r;
                end
                case (op_s)
                    OP_NOP: state_s = ST_FETCH;
                    OP_LAYER: begin
                        if (seen_r && (layer_r == LI_LAST)) begin
                            state_s = ST_ERR;
                        end else begin
                            // The first LAYER of a run selects layer 0.
                            layer_s = seen_r ? (layer_r + LI_W'(1)) : {LI_W{1'b0}};
                            seen_s  = 1'b1;
                            dense_s = arg_s[7:4];
                            act_s   = arg_s[3:0];
                            rows_s  = {ROW_W{1'b0}};
                        end
                    end
                    OP_ROWS: rows_s = arg_s[ROW_W-1:0];
                    OP_COST: cost_s = arg_s[7:0];
                    OP_LOAD: begin
                        if (!seen_r) begin
                            state_s = ST_ERR;
                        end else if (rows_r == {ROW_W{1'b0}}) begin
                            state_s = ST_FETCH;
                        end else begin
                            state_s   = ST_LOAD_ROWS;
                            valid_s   = 1'b1;
                            row_idx_s = {ROW_W{1'b0}};
                        end
                    end
                    OP_FWD: begin
                        if (!seen_r) begin
                            state_s = ST_ERR;
                        end else begin
                            state_s     = ST_WAIT_FWD;
                            fwd_start_s = 1'b1;
                        end
                    end
                    OP_BWD: begin
`ifdef SEQ_BACKPROP_EN
                        state_s     = ST_WAIT_BWD;
                        bwd_start_s = 1'b1;
`else
                        state_s     = ST_ERR;
`endif
                    end
                    OP_END:  state_s = ST_DONE;
                    default: state_s = ST_ERR;
                endcase
            end
            ST_LOAD_ROWS: begin
                // Valid and row index are held until the loader takes the beat.
                if (valid_r && w_load_ready) begin
                    if (row_idx_r == (rows_r - ROW_W'(1))) begin
                        valid_s = 1'b0;
                        state_s = ST_FETCH;
                    end else begin
                        row_idx_s = row_idx_r + ROW_W'(1);
                    end
                end else begin
                    valid_s = valid_r;
                end
            end
            ST_WAIT_FWD: begin
                if (fwd_done) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_WAIT_FWD;
                end
            end
            ST_WAIT_BWD: begin
`ifdef SEQ_BACKPROP_EN
                if (bwd_done) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_WAIT_BWD;
                end
`else
                state_s = ST_ERR;
`endif
            end
            default: state_s = ST_ERR;
        endcase
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_r     <= ST_IDLE;
            pc_r        <= {PC_W{1'b0}};
            wrap_r      <= 1'b0;
            seen_r      <= 1'b0;
            layer_r     <= {LI_W{1'b0}};
            rows_r      <= {ROW_W{1'b0}};
            row_idx_r   <= {ROW_W{1'b0}};
            valid_r     <= 1'b0;
            fwd_start_r <= 1'b0;
            bwd_start_r <= 1'b0;
            act_r       <= 4'h0;
            dense_r     <= 4'h0;
            cost_r      <= 8'h00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            wrap_r      <= wrap_s;
            seen_r      <= seen_s;
            layer_r     <= layer_s;
            rows_r      <= rows_s;
            row_idx_r   <= row_idx_s;
            valid_r     <= valid_s;
            fwd_start_r <= fwd_start_s;
            bwd_start_r <= bwd_start_s;
            act_r       <= act_s;
            dense_r     <= dense_s;
            cost_r      <= cost_s;
            busy_r      <= is_busy_state(state_s);
            done_r      <= (state_s == ST_DONE);
            error_r     <= (state_s == ST_ERR);
        end
    end

    assign w_load_valid  = valid_r;
    assign w_layer_index = layer_r;
    assign w_row_index   = row_idx_r;
    assign fwd_start     = fwd_start_r;
    assign bwd_start     = bwd_start_r;
    assign act_type      = act_r;
    assign dense_type    = dense_r;
    assign cost_type     = cost_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;

endmodule
